// File: rtl/uart_tds_in.sv
// UART 8N1 receiver that packs eight accepted bytes, LSB byte first, into a 64-bit word.
// Define UART_TDS_IN_TIMEOUT_EN to discard partial words after TIMEOUT_BITS idle bit periods.
module uart_tds_in #(
  parameter int unsigned INPUT_CLOCK_FREQ = 240_000_000,
  parameter int unsigned BAUD_RATE        = 250_000,
  parameter int unsigned TIMEOUT_BITS     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [63:0] tds_word,
  output logic        tds_word_valid,
  output logic        framing_error,
  output logic        partial_drop
);

  localparam int unsigned BitCycles  = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HalfCycles = BitCycles / 2;
  localparam int unsigned CntW       = $clog2(BitCycles + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      idx_q, idx_d;
  logic [63:0]     asm_q, asm_d;
  logic [63:0]     word_q, word_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            drop_q, drop_d;
  logic            wait_high_q, wait_high_d;
  logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic            fall, tick, timeout;

  assign fall = rxd_prev_q & ~rxd_sync_q;
  assign tick = (cnt_q == CntW'(1));

`ifdef UART_TDS_IN_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * BitCycles;

  logic [31:0] idle_cnt_q, idle_cnt_d;

  assign timeout = (state_q == StIdle) && (idx_q != 3'd0) &&
                   (idle_cnt_q == 32'(TimeoutCycles - 1));

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == StIdle) && (idx_q != 3'd0) && !fall && !timeout) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    word_d      = word_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    drop_d      = 1'b0;
    wait_high_d = wait_high_q;
    unique case (state_q)
      StIdle: begin
        if (timeout) begin
          idx_d  = '0;
          drop_d = 1'b1;
        end
        // After a bad stop bit the line may still be low; re-arm only once it is high.
        if (wait_high_q) begin
          if (rxd_sync_q) wait_high_d = 1'b0;
        end else if (fall) begin
          state_d = StStart;
          cnt_d   = CntW'(HalfCycles);
        end
      end
      StStart: begin
        if (tick) begin
          if (!rxd_sync_q) begin
            state_d = StData;
            cnt_d   = CntW'(BitCycles);
            bit_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {rxd_sync_q, shift_q[7:1]};
          cnt_d   = CntW'(BitCycles);
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          if (rxd_sync_q) begin
            asm_d[{idx_q, 3'b000} +: 8] = shift_q;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              word_d  = {shift_q, asm_q[55:0]};
              valid_d = 1'b1;
            end
          end else begin
            ferr_d      = 1'b1;
            idx_d       = '0;
            wait_high_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      drop_q      <= 1'b0;
      wait_high_q <= 1'b0;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      drop_q      <= drop_d;
      wait_high_q <= wait_high_d;
      rxd_meta_q  <= uart_rxd;
      rxd_sync_q  <= rxd_meta_q;
      rxd_prev_q  <= rxd_sync_q;
    end
  end

  assign tds_word       = word_q;
  assign tds_word_valid = valid_q;
  assign framing_error  = ferr_q;
  assign partial_drop   = drop_q;

endmodule
